// File: rtl/scr1_tcm_portb_arbiter.sv
// Port-B controller for the dual-port TCM: optional post-reset zero fill, then
// round-robin sharing of the single read/write port between m0 and m1.
module scr1_tcm_portb_arbiter #(
  parameter int unsigned SCR1_WIDTH     = 32,
  parameter int unsigned SCR1_SIZE      = 32'h00010000,
  parameter int unsigned SCR1_NBYTES    = SCR1_WIDTH / 8,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW            = $clog2(SCR1_SIZE) - 2
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   m0_req_i,
  input  logic                   m0_we_i,
  input  logic [SCR1_NBYTES-1:0] m0_be_i,
  input  logic [AW-1:0]          m0_addr_i,
  input  logic [SCR1_WIDTH-1:0]  m0_wdata_i,
  output logic                   m0_gnt_o,
  output logic                   m0_rvalid_o,
  output logic [SCR1_WIDTH-1:0]  m0_rdata_o,

  input  logic                   m1_req_i,
  input  logic                   m1_we_i,
  input  logic [SCR1_NBYTES-1:0] m1_be_i,
  input  logic [AW-1:0]          m1_addr_i,
  input  logic [SCR1_WIDTH-1:0]  m1_wdata_i,
  output logic                   m1_gnt_o,
  output logic                   m1_rvalid_o,
  output logic [SCR1_WIDTH-1:0]  m1_rdata_o,

  output logic                   mem_renb_o,
  output logic                   mem_wenb_o,
  output logic [SCR1_NBYTES-1:0] mem_webb_o,
  output logic [AW-1:0]          mem_addrb_o,
  output logic [SCR1_WIDTH-1:0]  mem_datab_o,
  input  logic [SCR1_WIDTH-1:0]  mem_qb_i,

  output logic                   init_done_o
);

  localparam int unsigned   Words    = SCR1_SIZE / SCR1_NBYTES;
  localparam logic [AW-1:0] LastWord = AW'(Words - 1);

  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;

  logic          state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rr_last_q, rr_last_d;   // 1: m1 was granted last
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_owner_q, rsp_owner_d;
  logic          rsp_read_q, rsp_read_d;

  logic                   run;
  logic                   clearing;
  logic                   gnt0, gnt1, gnt_any;
  logic                   sel_we;
  logic [SCR1_NBYTES-1:0] sel_be;
  logic [AW-1:0]          sel_addr;
  logic [SCR1_WIDTH-1:0]  sel_wdata;

  assign run      = (state_q == StRun);
  // Gated by rst so every output reads zero while reset is held.
  assign clearing = (state_q == StInit) && CLEAR_ON_RESET && !rst;

  assign gnt0    = run && m0_req_i && (!m1_req_i || rr_last_q);
  assign gnt1    = run && m1_req_i && (!m0_req_i || !rr_last_q);
  assign gnt_any = gnt0 || gnt1;

  assign sel_we    = gnt1 ? m1_we_i    : m0_we_i;
  assign sel_be    = gnt1 ? m1_be_i    : m0_be_i;
  assign sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      if (CLEAR_ON_RESET) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastWord) begin
          state_d = StRun;
        end
      end else begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
    rr_last_d   = rr_last_q;
    if (gnt0) begin
      rr_last_d = 1'b0;
    end else if (gnt1) begin
      rr_last_d = 1'b1;
    end
    rsp_valid_d = gnt_any;
    rsp_owner_d = gnt1;
    rsp_read_d  = gnt_any && !sel_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      rr_last_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_read_q  <= rsp_read_d;
    end
  end

  always_comb begin
    mem_renb_o  = 1'b0;
    mem_wenb_o  = 1'b0;
    mem_webb_o  = '0;
    mem_addrb_o = '0;
    mem_datab_o = '0;
    if (clearing) begin
      mem_wenb_o  = 1'b1;
      mem_webb_o  = '1;
      mem_addrb_o = cnt_q;
    end else if (gnt_any) begin
      mem_addrb_o = sel_addr;
      if (sel_we) begin
        mem_wenb_o  = 1'b1;
        mem_webb_o  = sel_be;
        mem_datab_o = sel_wdata;
      end else begin
        mem_renb_o  = 1'b1;
      end
    end
  end

  always_comb begin
    m0_rvalid_o = rsp_valid_q && !rsp_owner_q;
    m1_rvalid_o = rsp_valid_q && rsp_owner_q;
    m0_rdata_o  = (m0_rvalid_o && rsp_read_q) ? mem_qb_i : '0;
    m1_rdata_o  = (m1_rvalid_o && rsp_read_q) ? mem_qb_i : '0;
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign init_done_o = run;

endmodule

// File: tb/tb_scr1_tcm_portb_arbiter.sv
// Bench for scr1_tcm_portb_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level model of the port.
module tb_scr1_tcm_portb_arbiter;

  localparam int W     = 32;
  localparam int SIZE  = 64;
  localparam int NB    = 4;
  localparam int AW    = 4;
  localparam int WORDS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m1_req, m1_we;
  logic [NB-1:0] m0_be, m1_be;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [W-1:0]  m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [W-1:0]  m0_rdata, m1_rdata;
  logic          mem_renb, mem_wenb, init_done;
  logic [NB-1:0] mem_webb;
  logic [AW-1:0] mem_addrb;
  logic [W-1:0]  mem_datab, mem_qb;

  // Second instance without clearing; only its init behaviour is observed.
  logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [W-1:0]  b_m0_rdata, b_m1_rdata, b_datab;
  logic          b_renb, b_wenb, b_init_done;
  logic [NB-1:0] b_webb;
  logic [AW-1:0] b_addrb;

  scr1_tcm_portb_arbiter #(.SCR1_WIDTH(W), .SCR1_SIZE(SIZE), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_renb_o(mem_renb), .mem_wenb_o(mem_wenb), .mem_webb_o(mem_webb),
    .mem_addrb_o(mem_addrb), .mem_datab_o(mem_datab), .mem_qb_i(mem_qb),
    .init_done_o(init_done)
  );

  scr1_tcm_portb_arbiter #(.SCR1_WIDTH(W), .SCR1_SIZE(SIZE), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req_i(1'b0), .m0_we_i(1'b0), .m0_be_i(4'h0), .m0_addr_i(4'h0),
    .m0_wdata_i(32'h0), .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_be_i(4'h0), .m1_addr_i(4'h0),
    .m1_wdata_i(32'h0), .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
    .mem_renb_o(b_renb), .mem_wenb_o(b_wenb), .mem_webb_o(b_webb),
    .mem_addrb_o(b_addrb), .mem_datab_o(b_datab), .mem_qb_i(32'h0),
    .init_done_o(b_init_done)
  );

  // Physical memory behind port B, seeded with garbage so the clear is visible.
  logic [W-1:0] pmem [WORDS] = '{default: 32'hA5A5_5A5A};
  always @(posedge clk) begin
    if (mem_renb) mem_qb <= pmem[mem_addrb];
    if (mem_wenb)
      for (int b = 0; b < NB; b++)
        if (mem_webb[b]) pmem[mem_addrb][8*b +: 8] <= mem_datab[8*b +: 8];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: counts clear cycles, then arbitrates and answers
  // each granted access one cycle later from its own copy of the array.
  bit           m_run;
  int           m_cnt;
  int           m_rr;        // requester granted last
  bit           m_rv;
  int           m_own;
  logic [W-1:0] m_rdat;
  logic [W-1:0] m_mem [WORDS];
  int           b_cnt;

  always @(negedge clk) begin
    int           g;
    bit           was_run, e_ren, e_wen, s_we;
    logic [3:0]   e_webb, e_addr, s_be, s_addr;
    logic [W-1:0] e_dat, s_wd;
    if (rst) begin
      chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      chk("rst_rdata", m0_rdata | m1_rdata, 0);
      chk("rst_mem", {mem_renb, mem_wenb, mem_webb, mem_addrb}, 0);
      chk("rst_init_done", {init_done, b_init_done}, 0);
      m_run = 0; m_cnt = 0; m_rr = 1; m_rv = 0; b_cnt = 0;
    end else begin
      chk("b_init_done", 32'(b_init_done), 32'(b_cnt >= 1));
      chk("b_no_wenb", 32'(b_wenb), 0);
      b_cnt++;
      g = -1; was_run = m_run;
      e_ren = 0; e_wen = 0; e_webb = 0; e_addr = 0; e_dat = 0;
      s_we = 0; s_be = 0; s_addr = 0; s_wd = 0;
      if (!m_run) begin
        e_wen = 1; e_webb = 4'hF; e_addr = 4'(m_cnt);
        m_mem[m_cnt] = 0;
        m_cnt++;
        if (m_cnt == WORDS) m_run = 1;
      end else begin
        if (m0_req && m1_req) g = (m_rr == 1) ? 0 : 1;
        else if (m0_req) g = 0;
        else if (m1_req) g = 1;
        if (g == 0) begin s_we = m0_we; s_be = m0_be; s_addr = m0_addr; s_wd = m0_wdata; end
        if (g == 1) begin s_we = m1_we; s_be = m1_be; s_addr = m1_addr; s_wd = m1_wdata; end
        if (g >= 0) begin
          e_addr = s_addr;
          if (s_we) begin e_wen = 1; e_webb = s_be; e_dat = s_wd; end
          else e_ren = 1;
        end
      end
      chk("gnt0", 32'(m0_gnt), 32'(g == 0));
      chk("gnt1", 32'(m1_gnt), 32'(g == 1));
      chk("init_done", 32'(init_done), 32'(was_run));
      chk("renb", 32'(mem_renb), 32'(e_ren));
      chk("wenb", 32'(mem_wenb), 32'(e_wen));
      chk("addrb", 32'(mem_addrb), 32'(e_addr));
      if (!e_ren) begin
        chk("webb", 32'(mem_webb), 32'(e_webb));
        chk("datab", mem_datab, e_dat);
      end
      chk("rvalid0", 32'(m0_rvalid), 32'(m_rv && m_own == 0));
      chk("rvalid1", 32'(m1_rvalid), 32'(m_rv && m_own == 1));
      chk("rdata0", m0_rdata, (m_rv && m_own == 0) ? m_rdat : 32'h0);
      chk("rdata1", m1_rdata, (m_rv && m_own == 1) ? m_rdat : 32'h0);
      m_rv = (g >= 0);
      m_own = g;
      m_rdat = s_we ? 32'h0 : m_mem[s_addr];
      if (g >= 0) begin
        m_rr = g;
        if (s_we)
          for (int b = 0; b < NB; b++)
            if (s_be[b]) m_mem[s_addr][8*b +: 8] = s_wd[8*b +: 8];
      end
    end
  end

  task automatic acc(input int m, input logic we, input logic [3:0] be, input logic [3:0] a,
                     input logic [31:0] wd, output logic [31:0] rd);
    if (m == 0) begin m0_req = 1; m0_we = we; m0_be = be; m0_addr = a; m0_wdata = wd; end
    else begin m1_req = 1; m1_we = we; m1_be = be; m1_addr = a; m1_wdata = wd; end
    @(negedge clk);
    chk("acc_gnt", 32'(m == 0 ? m0_gnt : m1_gnt), 1);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    chk("acc_rvalid", 32'(m == 0 ? m0_rvalid : m1_rvalid), 1);
    rd = (m == 0) ? m0_rdata : m1_rdata;
    @(posedge clk); #1;
  endtask

  task automatic run_init_lit(input string tag);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) chk({tag, "_addr0"}, 32'(mem_addrb), 0);
      if (c == 16) chk({tag, "_addr15"}, 32'(mem_addrb), 15);
      chk({tag, "_wenb"}, 32'(mem_wenb), 1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit g0, g1;
    rst = 1;
    m0_req = 1; m0_we = 0; m0_be = 0; m0_addr = 2; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run_init_lit("init");
    @(negedge clk);
    chk("init_done_c17", 32'(init_done), 1);
    chk("first_run_gnt", 32'(m0_gnt), 1);
    @(posedge clk); #1 m0_req = 0;

    acc(0, 1, 4'hF, 3, 32'hDEADBEEF, rd);
    chk("wr_ack_rdata", rd, 32'h0);
    acc(0, 0, 4'h0, 3, 32'h0, rd);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);
    acc(0, 1, 4'b0101, 5, 32'hAABBCCDD, rd);
    acc(0, 0, 4'h0, 5, 32'h0, rd);
    chk("rd_be_merge", rd, 32'h00BB00DD);

    acc(1, 1, 4'hF, 7, 32'h1234_5678, rd);
    m0_req = 1; m0_we = 0; m0_addr = 1;
    m1_req = 1; m1_we = 0; m1_addr = 2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("both_gnt0", 32'(m0_gnt), 32'(k % 2 == 0));
      chk("both_gnt1", 32'(m1_gnt), 32'(k % 2 == 1));
      if (k > 0) chk("both_rv0", 32'(m0_rvalid), 32'(k % 2 == 1));
      @(posedge clk); #1;
    end
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    chk("both_last_rv1", 32'(m1_rvalid), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      @(posedge clk); #1;
      if (!m0_req || g0) begin
        m0_req = ($urandom_range(0, 99) < 55); m0_we = 1'($urandom); m0_be = 4'($urandom);
        m0_addr = 4'($urandom_range(0, 15)); m0_wdata = $urandom;
      end
      if (!m1_req || g1) begin
        m1_req = ($urandom_range(0, 99) < 55); m1_we = 1'($urandom); m1_be = 4'($urandom);
        m1_addr = 4'($urandom_range(0, 15)); m1_wdata = $urandom;
      end
    end
    @(negedge clk);
    @(posedge clk); #1 m0_req = 0; m1_req = 0;

    // Reset during the clear, at word 7.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    chk("mid_init_addr7", 32'(mem_addrb), 7);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("mid_init_rst_wenb", 32'(mem_wenb), 0);
    @(posedge clk); #1 rst = 0;
    run_init_lit("reinit");
    @(negedge clk);
    chk("reinit_done", 32'(init_done), 1);
    @(posedge clk); #1;

    // Reset with an m1 read response in flight.
    m1_req = 1; m1_we = 0; m1_addr = 4;
    @(negedge clk);
    chk("m1_rd_gnt", 32'(m1_gnt), 1);
    @(posedge clk); #1 m1_req = 0; rst = 1;
    @(negedge clk);
    chk("inflight_dropped", 32'(m1_rvalid), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("restart_addr0", 32'(mem_addrb), 0);
    chk("restart_wenb", 32'(mem_wenb), 1);
    repeat (20) @(negedge clk);
    chk("final_init_done", 32'(init_done), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_portb_arbiter.md
Name: scr1_tcm_portb_arbiter

Overview:
Controller in front of port B of the dual-port TCM. It shares that single read/write port between two requesters: m0 (core data path) and m1 (debug/loader DMA). After reset it optionally zero-fills the whole array before granting any access. Port A (instruction fetch) is not touched by this block.

Parameters:
SCR1_WIDTH, 32, data word width in bits
SCR1_SIZE, 32'h00010000, memory size in bytes; word address width AW = $clog2(SCR1_SIZE)-2
SCR1_NBYTES, SCR1_WIDTH/8, byte enables per word
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = skip init

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
m0_req  in  1  m0 access request, held until granted
m0_we  in  1  1 = write, 0 = read
m0_be  in  SCR1_NBYTES  m0 byte enables (writes only)
m0_addr  in  AW  m0 word address
m0_wdata  in  SCR1_WIDTH  m0 write data
m0_gnt  out  1  m0 request accepted this cycle
m0_rvalid  out  1  m0 response (read data or write ack)
m0_rdata  out  SCR1_WIDTH  m0 read data
m1_*  same set as m0_*, for requester m1
mem_renb  out  1  to memory renb
mem_wenb  out  1  to memory wenb
mem_webb  out  SCR1_NBYTES  to memory webb
mem_addrb  out  AW  to memory addrb
mem_datab  out  SCR1_WIDTH  to memory datab
mem_qb  in  SCR1_WIDTH  memory read data, valid 1 cycle after renb
init_done  out  1  high once the array is usable

Behaviour:
- Reset (async assert): state=INIT, word counter=0, rr_last=1 (m0 wins the first tie). No pending response. All outputs 0.
- FSM states: INIT, RUN.
- INIT with CLEAR_ON_RESET=1: each cycle drive mem_wenb=1, mem_webb=all ones, mem_datab=0, mem_addrb=counter, mem_renb=0. Counter increments each cycle. After word WORDS-1 (WORDS = SCR1_SIZE/SCR1_NBYTES) is written, go to RUN; init_done=1 from the next cycle on. Full clear takes exactly WORDS cycles.
- INIT with CLEAR_ON_RESET=0: no writes; go to RUN on the first clock after reset deassert.
- In INIT: gnt=0 for both requesters; requests stay pending and are neither dropped nor latched.
- RUN, grant (combinational, same cycle as req): one grant at most per cycle.
  - Only one requester active: grant it.
  - Both active: grant the one that is not rr_last.
  - rr_last updates to the granted requester on every grant.
- RUN, memory drive (combinational from the granted request):
  - mem_addrb = addr.
  - Read: mem_renb=1, mem_wenb=0.
  - Write: mem_wenb=1, mem_webb=be, mem_datab=wdata, mem_renb=0.
  - No grant: all mem_* = 0.
- Response: registered owner/type. In the cycle after a grant, the owner's rvalid=1 for exactly one cycle.
  - Read: rdata = mem_qb.
  - Write: rdata = 0.
  - rdata of the non-owner, and of any idle requester, is 0.
- Pipelining: back-to-back grants are allowed every cycle, and response N overlaps grant N+1. Read latency is fixed at 1 cycle. There is no backpressure on responses.
- Write with be=0: still granted and acked; the memory is unchanged.
- Same-address write then read on consecutive cycles: the read returns the newly written data.
- Reset mid-operation (INIT or RUN): the in-flight response is discarded (no rvalid), state returns to INIT, and the clear restarts from word 0.

Test Plan:
- SCR1_SIZE=64 (16 words), CLEAR_ON_RESET=1, release rst -> mem_wenb high 16 cycles, addrb 0..15, datab=0; init_done=1 on cycle 17; m0_req held during init -> m0_gnt=0 throughout, granted the first RUN cycle.
- m0 write addr 3, be=4'b1111, wdata=32'hDEADBEEF; then m0 read addr 3 -> m0_gnt on each request cycle; write ack rvalid with rdata=0; read rvalid 1 cycle after its grant with rdata=32'hDEADBEEF.
- Byte-enable write: addr 5 be=4'b0101 wdata=32'hAABBCCDD after clear -> read addr 5 returns 32'h00BB00DD.
- m0 and m1 both hold read req for 4 cycles -> grants m0,m1,m0,m1; each rvalid goes to the matching requester one cycle later; other rvalid=0.
- CLEAR_ON_RESET=0 -> init_done=1 one clock after reset release, no mem_wenb pulses.
- Assert rst at init word 7, and again one cycle after an m1 read grant -> no rvalid emitted; the clear restarts at addrb 0 after reset release.
